// File: rtl/line_fill_pkg.sv
// line_fill_pkg: AXI read constants and FSM encoding shared by the line fill engine.
package line_fill_pkg;
  localparam int H_PIX_DEF = 640;
  localparam logic [2:0] ARSIZE_4B = 3'b010;
  localparam logic [1:0] ARBURST_INCR = 2'b01;
  localparam logic [1:0] RRESP_OKAY = 2'b00;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FLUSH} state_t;
endpackage

// File: rtl/line_fill_unpack.sv
// line_fill_unpack: splits each 32-bit beat into two registered 16-bit line-buffer writes,
// holding the odd pixel for one cycle and gating RREADY while it is pending.
module line_fill_unpack
  import line_fill_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_active,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  output logic        o_rready,
  output logic        o_beat,
  output logic        o_pending,
  output logic [9:0]  o_wr_addr,
  output logic [15:0] o_wr_data,
  output logic        o_wr_en
);
  logic        r_pend;
  logic [15:0] r_odd;
  logic [9:0]  r_pix;
  logic [9:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en;
  logic        w_beat;

  assign o_rready  = i_active & ~r_pend;
  assign w_beat    = o_rready & i_rvalid;
  assign o_beat    = w_beat;
  assign o_pending = r_pend;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_en   = r_wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_pend    <= 1'b0;
      r_odd     <= '0;
      r_pix     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= w_beat | r_pend;
      if (w_beat) begin
        r_wr_data <= i_rdata[15:0];
        r_odd     <= i_rdata[31:16];
        r_pend    <= 1'b1;
      end else if (r_pend) begin
        r_wr_data <= r_odd;
        r_pend    <= 1'b0;
      end
      if (w_beat | r_pend) begin
        r_wr_addr <= r_pix;
        r_pix     <= r_pix + 10'd1;
      end
      if (i_clr) r_pix <= '0;
    end
endmodule

// File: rtl/line_fill_ctl.sv
// line_fill_ctl: fetches one RGB565 display line over AXI4 read bursts and streams it,
// one pixel per clock, into the line buffer write port.
module line_fill_ctl
  import line_fill_pkg::*;
#(
  parameter int H_PIX       = H_PIX_DEF,
  parameter int BURST_LEN   = 16,
  parameter int LINE_STRIDE = 1280
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fb_base,
  input  logic        i_line_start,
  input  logic [8:0]  i_line_num,
  output logic [31:0] o_araddr,
  output logic [7:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [9:0]  o_line_wr_addr,
  output logic [15:0] o_line_wr_data,
  output logic        o_line_wr_en,
  output logic        o_busy,
  output logic        o_overrun,
  output logic        o_rd_err
);
  localparam int N_BURST = H_PIX / (2 * BURST_LEN);
  localparam int BW = N_BURST > 1 ? $clog2(N_BURST) : 1;
  localparam logic [BW-1:0] LAST_BURST = BW'(N_BURST - 1);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [31:0] BSTEP = 32'(BURST_LEN * 4);

  state_t        r_state;
  logic          r_arvalid;
  logic [31:0]   r_araddr;
  logic [BW-1:0] r_burst;
  logic [7:0]    r_beat;
  logic          r_overrun;
  logic          r_rd_err;
  logic          w_beat;
  logic          w_pending;
  logic          w_start;
  logic          w_unused;

  assign w_start   = (r_state == S_IDLE) & i_line_start;
  // RLAST is redundant with the beat counter, which alone ends a burst
  assign w_unused  = i_rlast;
  assign o_araddr  = r_araddr;
  assign o_arlen   = LAST_BEAT;
  assign o_arsize  = ARSIZE_4B;
  assign o_arburst = ARBURST_INCR;
  assign o_arvalid = r_arvalid;
  assign o_busy    = r_state != S_IDLE;
  assign o_overrun = r_overrun;
  assign o_rd_err  = r_rd_err;

  line_fill_unpack u_unpack (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_start),
    .i_active  (r_state == S_DATA),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .o_rready  (o_rready),
    .o_beat    (w_beat),
    .o_pending (w_pending),
    .o_wr_addr (o_line_wr_addr),
    .o_wr_data (o_line_wr_data),
    .o_wr_en   (o_line_wr_en)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_overrun <= 1'b0;
      r_rd_err  <= 1'b0;
    end else begin
      r_overrun <= i_line_start & (r_state != S_IDLE);
      if (w_beat && i_rresp != RRESP_OKAY) r_rd_err <= 1'b1;
      case (r_state)
        S_IDLE: if (i_line_start) begin
          r_state   <= S_ADDR;
          r_arvalid <= 1'b1;
          r_araddr  <= i_fb_base + 32'(i_line_num) * 32'(LINE_STRIDE);
          r_burst   <= '0;
          r_rd_err  <= 1'b0;
        end
        S_ADDR: if (i_arready) begin
          r_state   <= S_DATA;
          r_arvalid <= 1'b0;
          r_beat    <= '0;
        end
        S_DATA: if (w_beat) begin
          r_beat <= r_beat + 8'd1;
          if (r_beat == LAST_BEAT) begin
            if (r_burst == LAST_BURST) r_state <= S_FLUSH;
            else begin
              r_state   <= S_ADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= r_araddr + BSTEP;
              r_burst   <= r_burst + BW'(1);
            end
          end
        end
        // hold until the final odd pixel has been written so Busy covers it
        default: if (!w_pending) r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_line_fill_ctl.sv
// tb_line_fill_ctl: randomized AXI slave with a pixel scoreboard checking line_fill_ctl.
module tb_line_fill_ctl;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic [31:0] fb_base, araddr, rdata;
  logic        line_start, arvalid, arready, rlast, rvalid, rready, wr_en, busy, overrun, rd_err;
  logic [8:0]  line_num;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data;

  line_fill_ctl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_fb_base(fb_base), .i_line_start(line_start),
    .i_line_num(line_num), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arvalid(arvalid), .i_arready(arready), .i_rdata(rdata),
    .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid), .o_rready(rready),
    .o_line_wr_addr(wr_addr), .o_line_wr_data(wr_data), .o_line_wr_en(wr_en),
    .o_busy(busy), .o_overrun(overrun), .o_rd_err(rd_err)
  );

  int errors = 0, checks = 0;
  int ar_delay = 0, gap_pct = 0, err_beat = -1;
  bit force_first = 0;
  logic [31:0] exp_base = 0, prev_araddr;
  logic [15:0] expq[$];
  logic [15:0] w0, w1, d;
  int exp_addr = 0, nbursts = 0, beats_owed = 0, beat_idx = 0, ar_wait = 0;
  bit r_taken, exp_rderr, last_flag, prev_rfire, prev2_rfire, prev_arfire, prev_stall;

  // AXI slave + scoreboard: drives at negedge+1, then judges what the DUT shows this cycle
  // and records the handshakes that will occur at the coming posedge.
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        arready = 0; rvalid = 0; rlast = 0; r_taken = 0; beats_owed = 0; expq.delete();
        exp_addr = 0; nbursts = 0; beat_idx = 0; exp_rderr = 0; last_flag = 0; ar_wait = 0;
        prev_rfire = 0; prev2_rfire = 0; prev_arfire = 0; prev_stall = 0;
        continue;
      end
      if (arvalid) begin
        arready = ar_wait >= ar_delay;
        if (!arready) ar_wait++;
      end else arready = (ar_delay == 0);
      if (!(rvalid && !r_taken)) begin
        if (beats_owed > 0 && $urandom_range(99) >= gap_pct) begin
          rvalid = 1;
          rdata = (force_first && beat_idx == 0) ? 32'hBBBB_AAAA : $urandom;
          rresp = (beat_idx == err_beat) ? 2'b10 : 2'b00;
          rlast = (beats_owed == 1);
        end else begin
          rvalid = 0; rlast = 0;
        end
      end
      r_taken = 0;
      if (prev_arfire) begin
        checks++;
        if (rready !== 1'b1) begin errors++; $display("FAIL rready_after_ar: got %b want 1", rready); end
      end
      if (prev_rfire || prev2_rfire) begin
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL write_latency: wr_en=%b want 1", wr_en); end
      end
      if (prev_rfire) begin
        checks++;
        if (rready !== 1'b0) begin errors++; $display("FAIL rready_odd: got %b want 0", rready); end
      end
      if (prev_stall && arvalid) begin
        checks++;
        if (araddr !== prev_araddr) begin errors++; $display("FAIL araddr_stable: got %h want %h", araddr, prev_araddr); end
      end
      checks++;
      if (rd_err !== exp_rderr) begin errors++; $display("FAIL rd_err: got %b want %b", rd_err, exp_rderr); end
      if (last_flag) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busy); end
        last_flag = 0;
      end
      if (wr_en) begin
        checks++;
        if (expq.size() == 0) begin errors++; $display("FAIL spurious_write: addr %0d data %h", wr_addr, wr_data); end
        else begin
          d = expq.pop_front();
          if (wr_addr !== exp_addr[9:0] || wr_data !== d) begin
            errors++; $display("FAIL pixel: got addr %0d data %h want addr %0d data %h", wr_addr, wr_data, exp_addr, d);
          end
        end
        if (exp_addr == 0) w0 = wr_data;
        if (exp_addr == 1) w1 = wr_data;
        if (exp_addr == 639) begin
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL busy_last: got %b want 1", busy); end
          last_flag = 1;
        end
        exp_addr++;
      end
      if (line_start && !busy) begin
        exp_addr = 0; nbursts = 0; beat_idx = 0; exp_rderr = 0;
      end
      if (arvalid && beats_owed > 0) begin
        checks++; errors++; $display("FAIL ar_overlap: arvalid with %0d beats owed want 0", beats_owed);
      end
      prev_arfire = arvalid && arready;
      if (prev_arfire) begin
        checks++;
        if (araddr !== exp_base + 32'(nbursts * 64)) begin
          errors++; $display("FAIL araddr: burst %0d got %h want %h", nbursts, araddr, exp_base + 32'(nbursts * 64));
        end
        nbursts++; beats_owed = 16; ar_wait = 0;
      end
      prev_stall = arvalid && !arready;
      prev_araddr = araddr;
      prev2_rfire = prev_rfire;
      prev_rfire = rvalid && rready;
      if (prev_rfire) begin
        expq.push_back(rdata[15:0]); expq.push_back(rdata[31:16]);
        beats_owed--; beat_idx++; r_taken = 1;
        if (rresp != 2'b00) exp_rderr = 1;
      end
    end
  end

  task automatic start_line(input logic [31:0] fb, input logic [8:0] n);
    @(negedge clk);
    exp_base = fb + 32'(n) * 32'd1280;
    fb_base = fb; line_num = n; line_start = 1;
    @(negedge clk);
    line_start = 0;
    #2;
    checks++;
    if (busy !== 1'b1 || arvalid !== 1'b1) begin errors++; $display("FAIL start: busy=%b arvalid=%b want 1 1", busy, arvalid); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 4000) begin @(negedge clk); n++; end
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout: busy=%b want 0", busy); end
  endtask

  task automatic check_line();
    checks++;
    if (exp_addr != 640 || nbursts != 20 || expq.size() != 0) begin
      errors++; $display("FAIL line_counts: writes %0d bursts %0d left %0d want 640 20 0", exp_addr, nbursts, expq.size());
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({busy, arvalid, rready, wr_en, overrun, rd_err} !== 6'b0 || araddr !== 0 || wr_addr !== 0 || wr_data !== 0) begin
      errors++; $display("FAIL %s: busy%b arv%b rr%b we%b ov%b re%b araddr %h wa %h wd %h want all 0",
        nm, busy, arvalid, rready, wr_en, overrun, rd_err, araddr, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #2;
    check_zero("reset");
    checks++;
    if (arlen !== 8'd15 || arsize !== 3'b010 || arburst !== 2'b01) begin
      errors++; $display("FAIL ar_consts: %h %b %b want 0f 010 01", arlen, arsize, arburst);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_full_line();
    ar_delay = 0; gap_pct = 0; force_first = 1; err_beat = -1;
    start_line(32'h1000_0000, 9'd2);
    checks++;
    if (araddr !== 32'h1000_0A00) begin errors++; $display("FAIL first_araddr: got %h want 10000a00", araddr); end
    wait_idle();
    check_line();
    checks++;
    if (w0 !== 16'hAAAA || w1 !== 16'hBBBB) begin errors++; $display("FAIL first_pixels: got %h %h want aaaa bbbb", w0, w1); end
    force_first = 0;
  endtask

  task automatic test_stall();
    ar_delay = 5; gap_pct = 40;
    repeat (2) begin
      start_line($urandom, 9'($urandom_range(0, 511)));
      wait_idle();
      check_line();
    end
    ar_delay = 0; gap_pct = 0;
  endtask

  task automatic test_overrun();
    int n = 0;
    gap_pct = 20;
    start_line(32'h2000_0000, 9'd7);
    while (nbursts < 3 && n < 500) begin @(negedge clk); n++; end
    line_start = 1; line_num = 9'd9; fb_base = $urandom;
    @(negedge clk);
    line_start = 0;
    #2;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b want 1", overrun); end
    @(negedge clk); #2;
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    wait_idle();
    check_line();
    gap_pct = 0;
  endtask

  task automatic test_rd_err();
    err_beat = 100;
    start_line(32'h0123_4560, 9'd5);
    wait_idle();
    check_line();
    checks++;
    if (rd_err !== 1'b1) begin errors++; $display("FAIL rd_err_sticky: got %b want 1", rd_err); end
    err_beat = -1;
    start_line(32'h0123_4560, 9'd6);
    checks++;
    if (rd_err !== 1'b0) begin errors++; $display("FAIL rd_err_clear: got %b want 0", rd_err); end
    wait_idle();
    check_line();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    start_line(32'hFFFF_F000, 9'd511);
    while (!last_flag && n < 4000) begin @(negedge clk); #2; n++; end
    line_start = 1; line_num = 9'd3;
    @(negedge clk);
    line_start = 0;
    #2;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_overrun: ov=%b busy=%b want 1 0", overrun, busy); end
    @(negedge clk); #2;
    checks++;
    if (arvalid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_ignored: arv=%b busy=%b ov=%b want 0 0 0", arvalid, busy, overrun);
    end
    check_line();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    gap_pct = 10; err_beat = 3;
    start_line(32'h4000_0000, 9'd100);
    while (nbursts < 2 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    gap_pct = 0; err_beat = -1;
    start_line(32'h5000_0040, 9'd1);
    wait_idle();
    check_line();
  endtask

  initial begin
    line_start = 0; fb_base = 0; line_num = 0;
    test_reset();
    test_full_line();
    test_stall();
    test_overrun();
    test_rd_err();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
